fetch_decode_stage: RTL
=======================

// Module: fetch_decode_stage
// PURPOSE
//   Instruction fetch plus IF/ID pipeline register for the RV32 core. Keeps the PC, fetches
//   words from instruction memory through a req/ready handshake, and holds the fetched word.
//   Splits the held word into opcode/func3/func7/rd/rs1/rs2, which drive the control decoder
//   and the register file directly downstream. Supports stall, flush/redirect and halt on SYSTEM.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC loaded on reset; first fetch address
//   PC_STEP    4               PC increment per accepted fetch (bytes)
// PORTS
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   fetch request valid this cycle
//   imem_addr    out  32  fetch byte address (= pc register)
//   imem_ready   in   1   imem_rdata valid; transfer when imem_req && imem_ready
//   imem_rdata   in   32  instruction word
//   stall_i      in   1   downstream cannot accept; held word must not change
//   flush_i      in   1   discard held word and any same-cycle fetch; reload PC
//   redirect_pc  in   32  new PC used when flush_i=1
//   valid_o      out  1   held instruction is valid
//   pc_o         out  32  address of held instruction
//   opcode       out  7   ir[6:0]
//   rd           out  5   ir[11:7]
//   func3        out  3   ir[14:12]
//   rs1          out  5   ir[19:15]
//   rs2          out  5   ir[24:20]
//   func7        out  7   ir[31:25]
//   halted_o     out  1   FSM in HALT
// BEHAVIOUR
//   Reset (async on rst_n low): state=BOOT, pc=RESET_PC, ir=32'h0000_0013 (NOP), pc_o=0,
//     valid_o=0, halted_o=0, imem_req=0. The field outputs are always combinational slices of ir.
//   slot_free = !valid_o || !stall_i. fire = imem_req && imem_ready.
//   imem_req = (state==FETCH) && slot_free && !flush_i. imem_addr = pc at all times.
//   Handshake: the request is level-based per cycle. imem_req may drop without a transfer, and
//     imem_ready while imem_req=0 is ignored. Single-cycle transfer, no outstanding requests.
//   FSM:
//     BOOT  -> FETCH unconditionally, after one cycle (no request in BOOT).
//     FETCH: on fire, ir<=imem_rdata, pc_o<=pc, valid_o<=1, pc<=pc+PC_STEP (mod 2^32, wraps).
//            If imem_rdata[6:0]==7'b1110011 (SYSTEM), the word is still captured and the
//            state goes to HALT.
//            If there is no fire and valid_o && !stall_i, valid_o<=0 (word consumed, bubble).
//     HALT:  no requests. halted_o=1. The held word drains as in FETCH (valid_o clears when
//            consumed). Leaves only on flush_i.
//   flush_i (any state except BOOT) has top priority:
//     pc<=redirect_pc, valid_o<=0, state<=FETCH. imem_req is 0 that cycle, so there is no fire.
//     ir keeps its old value (fields are don't-care while valid_o=0).
//   Stall: while valid_o && stall_i, ir, pc_o and valid_o are frozen and imem_req=0.
//   Latency: the word appears on the outputs the cycle after fire. Throughput is one instruction
//     per cycle when imem_ready=1 and stall_i=0.
//   Simultaneous stall_i and flush_i: flush wins.
//   flush_i during BOOT: ignored.
//   Reset mid-fetch: everything returns to reset values immediately.
// TESTING
//   Reset release, imem_ready=1 -> cycle0 imem_req=0; cycle1 imem_req=1, addr=0; then addr 4, 8.
//   Fetch 32'h0020_81B3 at pc 0 -> next cycle valid_o=1, opcode=7'b0110011, rd=3, func3=0,
//     rs1=1, rs2=2, func7=0, pc_o=0.
//   Fetch 32'h4020_81B3 with stall_i=1 for 3 cycles -> outputs frozen, func7=32, imem_req=0,
//     pc unchanged; stall_i=0 -> fetch resumes at the next pc.
//   flush_i=1 with redirect_pc=32'h100 in the same cycle as imem_ready=1 -> word dropped,
//     valid_o=0, next imem_addr=32'h100.
//   Fetch 32'h0000_0073 -> halted_o=1, imem_req stays 0 for 10 cycles; flush_i with
//     redirect 32'h40 -> FETCH at 32'h40.
//   RESET_PC=32'hFFFF_FFFC -> first fetch at FFFF_FFFC, second at 0 (wrap). Assert rst_n
//     mid-stream -> valid_o=0 immediately.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - RV32 instruction fetch with IF/ID register and field split
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  func3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  func7,
  output logic        halted_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_hold_q, pc_hold_d;
  logic        valid_q, valid_d;

  logic slot_free;
  logic fire;
  logic consumed;

  assign slot_free = !valid_q || !stall_i;
  assign imem_req  = (state_q == ST_FETCH) && slot_free && !flush_i;
  assign fire      = imem_req && imem_ready;
  assign consumed  = valid_q && !stall_i;
  assign imem_addr = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    pc_hold_d = pc_hold_q;
    valid_d   = valid_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (fire) begin
          ir_d      = imem_rdata;
          pc_hold_d = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_q + 32'(PC_STEP);
          if (imem_rdata[6:0] == OPC_SYSTEM) begin
            state_d = ST_HALT;
          end
        end else if (consumed) begin
          valid_d = 1'b0;
        end
      end
      ST_HALT: begin
        if (consumed) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Redirect overrides everything but is meaningless before the first fetch slot.
    if (flush_i && (state_q != ST_BOOT)) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = ST_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BOOT;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_WORD;
      pc_hold_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      pc_hold_q <= pc_hold_d;
      valid_q   <= valid_d;
    end
  end

  assign valid_o  = valid_q;
  assign pc_o     = pc_hold_q;
  assign halted_o = (state_q == ST_HALT);

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign func3  = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign func7  = ir_q[31:25];

endmodule
